// File: rtl/sincronizador_param_if.sv
// Bundle of the crossing lines: the raw transmitter-side inputs plus the
// clean receiver-side value and its edge pulses.
interface sincronizador_param_if #(
  parameter int WIDTH = 1
) ();

  logic [WIDTH-1:0] dataAsync;
  logic [WIDTH-1:0] dataSync;
  logic [WIDTH-1:0] risePulse;
  logic [WIDTH-1:0] fallPulse;

  // Transmitter side drives the raw lines and observes the synchronized view
  modport master (
    output dataAsync,
    input  dataSync,
    input  risePulse,
    input  fallPulse
  );

  // Synchronizer side consumes the raw lines and produces the clean view
  modport slave (
    input  dataAsync,
    output dataSync,
    output risePulse,
    output fallPulse
  );

endinterface

// File: rtl/sincronizador_param.sv
// Multi-bit receiver-side synchronizer: a flop chain per bit, a per-bit
// persistence filter that only adopts a value once it has been seen for
// FILTER consecutive cycles, and registered rise/fall pulses for every
// adopted change.
module sincronizador_param #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter int               FILTER  = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                  clkRx,
  input  logic                  rst,
  sincronizador_param_if.slave  bus
);

  // Counter only has to reach FILTER-1; a 1-bit counter is kept even when
  // filtering is disabled so the array never collapses to zero width.
  localparam int             CW      = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER - 1);

  logic [WIDTH-1:0] stage_q [STAGES-1];
  logic [WIDTH-1:0] stage_d [STAGES-1];
  logic [CW-1:0]    cnt_q   [WIDTH];
  logic [CW-1:0]    cnt_d   [WIDTH];
  logic [WIDTH-1:0] data_sync_q;
  logic [WIDTH-1:0] data_sync_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] sync_w;

  // Pure shift chain: stage 0 is the only flop allowed to go metastable,
  // the rest just pass the value along with nothing in between.
  always_comb begin
    stage_d[0] = bus.dataAsync;
    for (int i = 1; i < STAGES - 1; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  assign sync_w = stage_q[STAGES-2];

  // Per-bit persistence filter: count consecutive mismatches and adopt the
  // new value on the FILTER-th one, firing the matching edge pulse.
  always_comb begin
    data_sync_d = data_sync_q;
    rise_d      = '0;
    fall_d      = '0;
    for (int b = 0; b < WIDTH; b++) begin
      cnt_d[b] = cnt_q[b];
      if (sync_w[b] == data_sync_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_MAX) begin
        data_sync_d[b] = sync_w[b];
        cnt_d[b]       = '0;
        rise_d[b]      = sync_w[b];
        fall_d[b]      = ~sync_w[b];
      end else begin
        cnt_d[b] = cnt_q[b] + CW'(1);
      end
    end
  end

  // All state loads the reset value together, so a reset never looks like
  // an edge and any partially counted change is discarded.
  always_ff @(posedge clkRx) begin
    if (rst) begin
      for (int i = 0; i < STAGES - 1; i++) begin
        stage_q[i] <= RST_VAL;
      end
      for (int b = 0; b < WIDTH; b++) begin
        cnt_q[b] <= '0;
      end
      data_sync_q <= RST_VAL;
      rise_q      <= '0;
      fall_q      <= '0;
    end else begin
      for (int i = 0; i < STAGES - 1; i++) begin
        stage_q[i] <= stage_d[i];
      end
      for (int b = 0; b < WIDTH; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
      data_sync_q <= data_sync_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
    end
  end

  assign bus.dataSync  = data_sync_q;
  assign bus.risePulse = rise_q;
  assign bus.fallPulse = fall_q;

endmodule

// File: doc/sincronizador_param.md
Name: sincronizador_param

Overview:
Parametrised multi-bit clock-domain-crossing synchronizer for the receiver side. It brings WIDTH asynchronous lines from the transmitter into the clkRx domain through a configurable-depth flip-flop chain. A per-bit stability filter (debounce) follows the chain, and the block generates registered rising- and falling-edge pulses. It replaces single-bit 2-FF synchronizers wherever receiver logic needs clean, glitch-free control or status bits plus edge events.

Parameters:
WIDTH, 1, number of independent channels (bits) synchronized in parallel.
STAGES, 2, total synchronizer depth including the output register; legal range ≥2.
FILTER, 1, consecutive clkRx cycles a new synchronized value must persist before dataSync adopts it; legal range ≥1; 1 disables filtering.
RST_VAL, {WIDTH{1'b0}}, value loaded into every stage and into dataSync on reset.

Ports:
clkRx  input  1  receiver clock; the only clock; all state updates on posedge.
rst  input  1  reset, synchronous and active-high; sampled on posedge clkRx.
dataAsync  input  WIDTH  asynchronous inputs from the transmitter domain; no timing relation to clkRx.
dataSync  output  WIDTH  synchronized, filtered value (registered).
risePulse  output  WIDTH  one-cycle pulse per bit on a dataSync 0->1 update (registered).
fallPulse  output  WIDTH  one-cycle pulse per bit on a dataSync 1->0 update (registered).

Behaviour:
- Reset (rst=1 at posedge): all chain stages <= RST_VAL; dataSync <= RST_VAL; all filter counters <= 0; risePulse = fallPulse = 0. Reset overrides any in-progress filtering. No pulse is generated by the reset load itself.
- Chain: STAGES-1 internal flops per bit, stage[0] <= dataAsync, stage[i] <= stage[i-1]; sync = stage[STAGES-2]. No combinational path from dataAsync to any output.
- Filter, per bit, with counter cnt of width max(1, clog2(FILTER)), evaluated each posedge when rst=0:
  - sync == dataSync: cnt <= 0; no pulse.
  - sync != dataSync and cnt == FILTER-1: dataSync <= sync; cnt <= 0; risePulse (if sync=1) or fallPulse (if sync=0) asserted for exactly this cycle.
  - Otherwise: cnt <= cnt+1; dataSync holds.
- Pulses are 0 in every cycle where the corresponding dataSync bit did not change on that edge. A pulse is never wider than one cycle, even for back-to-back updates.
- Latency: a change captured into stage[0] at edge E0 and held stable appears on dataSync at edge E0+STAGES+FILTER-2. With STAGES=2 and FILTER=1 this is E0+1, the classic 2-FF timing.
- Glitch rejection: a change on sync lasting fewer than FILTER consecutive cycles never reaches dataSync and produces no pulse. Its counter returns to 0 when sync re-matches dataSync.
- Channels are fully independent: separate counters, and simultaneous updates on different bits are allowed in the same cycle.
- cnt never exceeds FILTER-1; no wrap-around is possible.
- Metastability: only stage[0] may go metastable. Implementation keeps stage[0..STAGES-2] as plain flops with no logic between them.

Test Plan:
1. Reset: WIDTH=8, RST_VAL=8'hA5, dataAsync=8'hFF, rst=1 for 3 edges -> dataSync=8'hA5 and pulses=0 throughout; after release dataSync becomes 8'hFF at the expected latency, with risePulse=8'h5A for one cycle and fallPulse=0.
2. Baseline latency: STAGES=2, FILTER=1, WIDTH=1, RST_VAL=0; dataAsync 0->1 before edge E0 -> dataSync=1 and risePulse=1 after E0+1; risePulse=0 after E0+2; 1->0 later gives the mirror result on fallPulse.
3. Filtered latency: STAGES=3, FILTER=4, WIDTH=8, RST_VAL=0; bit3 raised before E0 and held -> dataSync[3]=1 with risePulse[3]=1 at edge E0+5, and no change before E0+5.
4. Glitch rejection: same configuration; bit5 high for 3 cycles, then low -> dataSync[5] stays 0 and no pulse; bit5 high for 4 cycles -> rises after the full latency, then falls 4 cycles after it drops.
5. Channel independence: WIDTH=4, FILTER=1, dataSync=4'b0010; dataAsync changed to 4'b0001 -> at the same edge risePulse=4'b0001 and fallPulse=4'b0010, other bits 0.
6. Reset mid-filter and toggling input: FILTER=4, counter at 2 when rst pulses one cycle -> dataSync=RST_VAL and counter=0, then full latency restarts. Separately, FILTER=2 with dataAsync toggling every clkRx cycle -> dataSync never changes and no pulses appear.
